// File: rtl/cpu_step_controller_if.sv
// Front-panel and CPU-side signal bundle for the CPU step controller.
// The master side owns the buttons and the CPU halt request; the slave is the controller.
interface cpu_step_controller_if;
  logic [3:0]  btn_n;
  logic        cpu_halt;
  logic        cpu_ce;
  logic        running;
  logic [1:0]  rate_sel;
  logic [15:0] ce_count;

  modport master (
    output btn_n,
    output cpu_halt,
    input  cpu_ce,
    input  running,
    input  rate_sel,
    input  ce_count
  );

  modport slave (
    input  btn_n,
    input  cpu_halt,
    output cpu_ce,
    output running,
    output rate_sel,
    output ce_count
  );
endinterface

// File: rtl/cpu_step_controller.sv
// Run/halt/single-step controller producing a CPU clock-enable at one of four rates.
// The buttons pass through synchronizers and debouncers, then drive a HALT/RUN/STEP FSM.
module cpu_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DIV0            = 16777216,
  parameter int unsigned DIV1            = 4194304,
  parameter int unsigned DIV2            = 1048576,
  parameter int unsigned DIV3            = 1,
  parameter bit          RUN_AT_RESET    = 1'b1
) (
  input  logic                  clk_50mhz,
  input  logic                  reset_n,
  cpu_step_controller_if.slave  bus
);

  localparam int unsigned          DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam state_t RESET_STATE = RUN_AT_RESET ? S_RUN : S_HALT;

  logic [3:0]            sync_q1;
  logic [3:0]            sync_q2;
  logic [3:0]            deb_q;
  logic [3:0]            press_q;
  logic [3:0][DB_W-1:0]  db_cnt_q;

  state_t       state_q, state_d;
  logic         cpu_ce_q, cpu_ce_d;
  logic         running_q;
  logic [1:0]   rate_q, rate_d;
  logic [15:0]  ce_count_q, ce_count_d;
  logic [24:0]  div_q, div_d;
  logic [24:0]  div_last;

  // Buttons idle high, so every stage resets to the released level.
  // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values together.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1  <= '1;
      sync_q2  <= '1;
      deb_q    <= '1;
      press_q  <= '0;
      // NOTE: the debounce counters are plain flops, not a RAM, so resetting them is free and required.
      db_cnt_q <= '0;
    end else begin
      sync_q1 <= bus.btn_n;
      sync_q2 <= sync_q1;
      press_q <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] != deb_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            deb_q[i]    <= sync_q2[i];
            db_cnt_q[i] <= '0;
            press_q[i]  <= ~sync_q2[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    case (rate_q)
      2'd0:    div_last = 25'(DIV0 - 1);
      2'd1:    div_last = 25'(DIV1 - 1);
      2'd2:    div_last = 25'(DIV2 - 1);
      default: div_last = 25'(DIV3 - 1);
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cpu_ce_d   = 1'b0;
    div_d      = '0;
    rate_d     = rate_q;
    ce_count_d = ce_count_q;

    case (state_q)
      S_HALT: begin
        if (press_q[0]) begin
          state_d = S_RUN;
        end else if (press_q[1]) begin
          state_d  = S_STEP;
          cpu_ce_d = 1'b1;
        end
      end
      S_STEP:  state_d = S_HALT;
      S_RUN: begin
        if (press_q[0] || bus.cpu_halt) state_d = S_HALT;
      end
      default: state_d = RESET_STATE;
    endcase

    // Divider only advances while RUN continues; exits and rate changes restart it.
    if (state_q == S_RUN && state_d == S_RUN && !press_q[2]) begin
      if (div_q == div_last) begin
        cpu_ce_d = 1'b1;
      end else begin
        div_d = div_q + 25'd1;
      end
    end

    if (press_q[2]) rate_d = rate_q + 2'd1;

    if (press_q[3]) begin
      ce_count_d = {15'd0, cpu_ce_d};
    end else if (cpu_ce_d) begin
      ce_count_d = ce_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      cpu_ce_q   <= 1'b0;
      running_q  <= RUN_AT_RESET;
      rate_q     <= 2'd0;
      ce_count_q <= 16'd0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      cpu_ce_q   <= cpu_ce_d;
      running_q  <= (state_d == S_RUN);
      rate_q     <= rate_d;
      ce_count_q <= ce_count_d;
      div_q      <= div_d;
    end
  end

  assign bus.cpu_ce   = cpu_ce_q;
  assign bus.running  = running_q;
  assign bus.rate_sel = rate_q;
  assign bus.ce_count = ce_count_q;

endmodule

// File: doc/cpu_step_controller.md
CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles for an accepted button press (10 ms at 50 MHz).
REQ-002 SHALL have parameters DIV0/DIV1/DIV2/DIV3, defaults 16777216/4194304/1048576/1, meaning clk_50mhz cycles per cpu_ce pulse at rate 0..3 (all >=1).
REQ-003 SHALL have parameter RUN_AT_RESET, default 1, meaning reset state RUN (1) or HALT (0).
REQ-004 clk_50mhz  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_n  input  4  raw asynchronous active-low buttons: [0] run/halt toggle, [1] single step, [2] rate cycle, [3] clear ce_count.
REQ-007 cpu_halt  input  1  synchronous level from CPU requesting halt (e.g. BRK).
REQ-008 cpu_ce  output  1  one-cycle clock-enable pulse advancing the CPU one cycle.
REQ-009 running  output  1  high while in RUN.
REQ-010 rate_sel  output  2  current rate index.
REQ-011 ce_count  output  16  count of cpu_ce pulses issued.

Function
REQ-012 SHALL pass each btn_n bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce per bit: the debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that bit's counter.
REQ-014 SHALL produce a one-cycle press pulse per bit on a debounced high->low transition; release produces no pulse; a held button produces exactly one pulse.
REQ-015 SHALL implement states HALT, RUN, STEP.
REQ-016 HALT: press[0] -> RUN; else press[1] -> STEP; else stay.
REQ-017 STEP: assert cpu_ce for exactly one cycle, then HALT unconditionally; presses arriving in STEP are dropped.
REQ-018 RUN: press[0] or cpu_halt -> HALT next cycle; press[1] ignored.
REQ-019 Simultaneous press[0] and press[1] in HALT: run toggle wins, step dropped.
REQ-020 cpu_halt high in HALT SHALL not block STEP, allowing the CPU to be stepped past a halt point.
REQ-021 Divider: 25-bit counter, held at 0 outside RUN; in RUN counts 0..DIV[rate_sel]-1, asserts cpu_ce on the cycle it equals DIV-1, then wraps to 0.
REQ-022 First cpu_ce after entering RUN SHALL occur exactly DIV[rate_sel] cycles after the transition cycle; DIV=1 gives cpu_ce every RUN cycle.
REQ-023 press[2] SHALL increment rate_sel modulo 4 (3 -> 0) and reset the divider counter to 0 in the same cycle, with no cpu_ce that cycle.
REQ-024 cpu_ce SHALL never be asserted in HALT, nor on the cycle RUN exits due to cpu_halt or press[0].
REQ-025 ce_count SHALL increment by 1 on every cpu_ce and wrap 0xFFFF -> 0x0000.
REQ-026 press[3] SHALL clear ce_count to 0; if it coincides with cpu_ce, the result is 1.
REQ-027 running SHALL be registered and equal (state==RUN); cpu_ce SHALL be registered, glitch-free.

Reset
REQ-028 reset_n low SHALL asynchronously force state=RUN if RUN_AT_RESET else HALT, cpu_ce=0, rate_sel=0, ce_count=0, divider=0, synchronizers/debounced levels=1 (released), debounce counters=0.
REQ-029 Reset mid-press or mid-STEP SHALL abort the step; no cpu_ce during reset or in the first cycle after release.
REQ-030 Button held low across reset release SHALL yield one press pulse after synchronization plus DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4, DIV0..3=8,4,2,1, RUN_AT_RESET=1)
REQ-031 Release reset, idle -> cpu_ce every 8 cycles, first exactly 8 cycles after reset release, running=1, ce_count increments per pulse.
REQ-032 btn_n[0] low 10 cycles -> HALT, running=0, no cpu_ce; then btn_n[1] low 10 cycles -> exactly one cpu_ce, ce_count +1, state HALT.
REQ-033 btn_n[1] bouncing (toggling every 2 cycles for 20 cycles, then held low) -> exactly one step pulse.
REQ-034 Four btn_n[2] presses in RUN -> rate_sel 1,2,3,0; at rate 3 cpu_ce every cycle; divider restarts on each change.
REQ-035 cpu_halt pulse in RUN -> HALT next cycle, no cpu_ce that cycle; btn_n[1] press while cpu_halt high -> one cpu_ce.
REQ-036 Preload ce_count to 0xFFFF via 65535 pulses at rate 3, one more -> 0x0000; btn_n[3] press coincident with cpu_ce -> ce_count=1.
